instr_reg_queue: RTL and testbench
==================================

Name: instr_reg_queue

Overview:
Parametrised instruction register with a DEPTH-entry prefetch queue, placed between the instruction-memory fetch path and the multicycle control unit.
- Fetched words are pushed over a valid/ready handshake and buffered in order.
- The control unit pulls the next word into the architectural IR with ir_load.
- Decoded fields (opcode, mode, rd, rs1, raw imm, sign-extended imm) come from the registered IR, not the queue head.
- flush discards all queued and held instructions, e.g. on a taken branch or jump.

Parameters:
INSTR_W, 16, instruction width in bits
OPCODE_W, 4, opcode field width, located at [INSTR_W-1 -: OPCODE_W]
REG_W, 3, width of the rd and rs1 fields
IMM_W, 5, immediate field width, located at [IMM_W-1:0]
XLEN, 16, datapath width for imm_ext
DEPTH, 4, queue entries; power of two, at least 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard queue contents and invalidate IR
in_valid  in  1  fetch word present on in_instr
in_instr  in  INSTR_W  fetched instruction word
in_ready  out  1  queue can accept a word; equals !full
ir_load  in  1  move queue head into IR
ir_valid  out  1  IR holds a live instruction
ir  out  INSTR_W  raw IR contents
opcode  out  OPCODE_W  ir[INSTR_W-1 -: OPCODE_W]
mode  out  1  ir[INSTR_W-OPCODE_W-1]
rd  out  REG_W  bits directly below mode
rs1  out  REG_W  bits directly below rd
imm  out  IMM_W  ir[IMM_W-1:0]
imm_ext  out  XLEN  imm sign-extended to XLEN
count  out  $clog2(DEPTH+1)  queued entries, excluding IR

Behaviour:
- Widths are checked at elaboration: OPCODE_W+1+2*REG_W+IMM_W must equal INSTR_W. A mismatch is a fatal $error.
- Reset (rst_n=0 at a clk edge):
  - rd/wr pointers = 0, count = 0.
  - ir = 0, ir_valid = 0, so all decoded fields read 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset overrides every other input, including an operation in flight.
- Push: occurs when in_valid && in_ready && !flush.
  - in_instr is written at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop/load: occurs when ir_load && count!=0 && !flush.
  - ir <= mem[rd_ptr], ir_valid <= 1, rd_ptr increments modulo DEPTH.
  - Latency: the word pushed at edge N is visible on ir no earlier than edge N+1, i.e. one cycle in the queue. The queue has no bypass path.
- ir_load with count==0: ir keeps its old contents and ir_valid <= 0, a fetch bubble. The control unit must wait for ir_valid.
- ir_load==0: ir and ir_valid hold.
- Simultaneous push and pop in one cycle is legal when 0<count<DEPTH. count is unchanged and both pointers advance.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored, even if the same cycle pops. There is no pop-credit to the ready signal.
- Empty: a push and an ir_load in the same cycle produce a bubble (ir_valid <= 0), and the pushed word lands in the queue.
- flush=1 has priority over push and load:
  - pointers = 0, count = 0, ir_valid <= 0, ir holds its value.
  - in_ready stays at !full, which is the pre-flush state in that cycle.
  - The word offered in the flush cycle is dropped.
- Decode is combinational from the registered ir, with no extra latency. imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}.
- Queue storage (mem) is not reset; only the pointers and count are.

Decomposition:
- Shared package ir_pkg:
  - default widths INSTR_W, OPCODE_W, REG_W, IMM_W, XLEN
  - field-offset localparams (OPC_LSB, MODE_BIT, RD_LSB, RS1_LSB)
  - a packed instr_t struct {opcode, mode, rd, rs1, imm}, reused by the decoder and the ALU control
- One sub-module, sync_fifo (DEPTH, WIDTH), holds the storage, pointers and count, with push/pop/flush inputs and full/empty outputs. instr_reg_queue adds the IR stage, bubble logic and field decode.

Test Plan:
1. Reset, then push 16'h3501 and raise ir_load two cycles later. Expect ir=16'h3501, opcode=4'b0011, mode=0, rd=3'b101, rs1=3'b000, imm=5'b00001, imm_ext=16'h0001, ir_valid=1.
2. Push 16'h6146 (imm=5'b00110), then 16'h601F (imm=5'b11111), then load both. Expect the first load gives imm_ext=16'h0006 and the second gives imm_ext=16'hFFFF, in push order.
3. Push 4 words with no load. Expect count=4 and in_ready=0. A fifth in_valid with simultaneous ir_load is not accepted: count=3 afterwards and the fifth word is absent. Continue with 6 alternating push/load pairs to exercise pointer wrap; order is preserved.
4. With count==0, assert in_valid=1 (16'h1234) and ir_load=1 together. Expect ir_valid=0 next cycle and count=1. Another ir_load gives ir=16'h1234.
5. Queue 3 words with ir_valid=1, then pulse flush while in_valid=1 and ir_load=1. Expect count=0, ir_valid=0, ir unchanged, and the flush-cycle word dropped. The next push and load returns only the new word.
6. Mid-stream (count=2), drive rst_n=0 for one edge together with in_valid and ir_load. Expect count=0, ir=0, ir_valid=0, in_ready=1, and all decoded fields 0.

Source files
------------

// File: rtl/instr_reg_queue_pkg.sv
// Shared instruction-format definitions for the fetch/decode front end.
// Field offsets are derived from the default widths; the struct mirrors one IR word.
package ir_pkg;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;
  localparam int REG_W    = 3;
  localparam int IMM_W    = 5;
  localparam int XLEN     = 16;

  localparam int OPC_LSB  = INSTR_W - OPCODE_W;
  localparam int MODE_BIT = OPC_LSB - 1;
  localparam int RD_LSB   = MODE_BIT - REG_W;
  localparam int RS1_LSB  = RD_LSB - REG_W;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                mode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [IMM_W-1:0]    imm;
  } instr_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_reg_queue_sync_fifo.sv
// In-order FIFO with pointers and occupancy count; storage itself is not reset.
// push/pop are requests; this block qualifies them against full/empty and flush.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rdata   = r_mem[r_rd_ptr];
  assign w_push  = push && !full && !flush;
  assign w_pop   = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push && rst_n) r_mem[r_wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_reg_queue.sv
// Instruction register fed by a prefetch queue; decoded fields come from the
// registered IR. An ir_load against an empty queue produces a fetch bubble.
module instr_reg_queue
  import ir_pkg::*;
#(
  parameter int INSTR_W  = ir_pkg::INSTR_W,
  parameter int OPCODE_W = ir_pkg::OPCODE_W,
  parameter int REG_W    = ir_pkg::REG_W,
  parameter int IMM_W    = ir_pkg::IMM_W,
  parameter int XLEN     = ir_pkg::XLEN,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  input  logic                       ir_load,
  output logic                       ir_valid,
  output logic [INSTR_W-1:0]         ir,
  output logic [OPCODE_W-1:0]        opcode,
  output logic                       mode,
  output logic [REG_W-1:0]           rd,
  output logic [REG_W-1:0]           rs1,
  output logic [IMM_W-1:0]           imm,
  output logic [XLEN-1:0]            imm_ext,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int OPC_LO   = INSTR_W - OPCODE_W;
  localparam int MODE_POS = OPC_LO - 1;
  localparam int RD_LO    = MODE_POS - REG_W;
  localparam int RS1_LO   = RD_LO - REG_W;

  if (OPCODE_W + 1 + 2*REG_W + IMM_W != INSTR_W) begin : g_bad_fields
    $error("instr_reg_queue: field widths do not sum to INSTR_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_reg_queue: DEPTH must be a power of two >= 2");
  end
  if (XLEN <= IMM_W) begin : g_bad_xlen
    $error("instr_reg_queue: XLEN must exceed IMM_W");
  end

  logic [INSTR_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [INSTR_W-1:0] r_ir;
  logic               r_ir_valid;

  // Handshake: a word transfers on a clk edge where in_valid && in_ready && !flush.
  // in_ready is !full only; it never looks at in_valid, ir_load or flush.
  assign in_ready = !w_full;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (ir_load),
    .flush (flush),
    .wdata (in_instr),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else if (flush) begin
      r_ir_valid <= 1'b0;
    end else if (ir_load) begin
      if (!w_empty) begin
        r_ir       <= w_head;
        r_ir_valid <= 1'b1;
      end else begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign opcode   = r_ir[OPC_LO +: OPCODE_W];
  assign mode     = r_ir[MODE_POS];
  assign rd       = r_ir[RD_LO +: REG_W];
  assign rs1      = r_ir[RS1_LO +: REG_W];
  assign imm      = r_ir[IMM_W-1:0];
  assign imm_ext  = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};

endmodule

// File: tb/tb_instr_reg_queue.sv
// Directed bench for instr_reg_queue: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_instr_reg_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        ir_load = 1'b0;
  logic        in_ready;
  logic        ir_valid;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic        mode;
  logic [2:0]  rd;
  logic [2:0]  rs1;
  logic [4:0]  imm;
  logic [15:0] imm_ext;
  logic [2:0]  count;

  instr_reg_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_ready(in_ready), .ir_load(ir_load),
    .ir_valid(ir_valid), .ir(ir), .opcode(opcode), .mode(mode), .rd(rd),
    .rs1(rs1), .imm(imm), .imm_ext(imm_ext), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: expected queue and IR state
  logic [15:0] exp_q[$];
  logic [15:0] m_ir = '0;
  logic        m_v = 1'b0;
  bit          m_live = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_ir = '0;
        m_v = 1'b0;
        m_live = 1'b1;
      end else if (flush) begin
        exp_q.delete();
        m_v = 1'b0;
      end else begin
        bit was_full;
        was_full = (exp_q.size() == DEPTH);
        if (ir_load) begin
          if (exp_q.size() != 0) begin
            m_ir = exp_q.pop_front();
            m_v = 1'b1;
          end else begin
            m_v = 1'b0;
          end
        end
        if (in_valid && !was_full) exp_q.push_back(in_instr);
      end
    end
  end

  // per-cycle compare on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        int          s;
        logic [4:0]  e_imm;
        logic [15:0] e_ext;
        s = exp_q.size();
        e_imm = 5'(m_ir % 32);
        e_ext = (e_imm >= 16) ? 16'(32'(e_imm) + 32'hFFE0) : 16'(e_imm);
        chk("m_count",    32'(count),    32'(s));
        chk("m_in_ready", 32'(in_ready), 32'(s != DEPTH));
        chk("m_ir_valid", 32'(ir_valid), 32'(m_v));
        chk("m_ir",       32'(ir),       32'(m_ir));
        chk("m_opcode",   32'(opcode),   32'(m_ir / 4096));
        chk("m_mode",     32'(mode),     32'((m_ir / 2048) % 2));
        chk("m_rd",       32'(rd),       32'((m_ir / 256) % 8));
        chk("m_rs1",      32'(rs1),      32'((m_ir / 32) % 8));
        chk("m_imm",      32'(imm),      32'(e_imm));
        chk("m_imm_ext",  32'(imm_ext),  32'(e_ext));
      end
    end
  end

  // driver: hold inputs across one rising edge, then return 2ns after it
  task automatic step(input logic r, input logic v, input logic [15:0] d,
                      input logic ld, input logic fl);
    rst_n = r; in_valid = v; in_instr = d; ir_load = ld; flush = fl;
    @(posedge clk);
    #2;
    rst_n = 1'b1; in_valid = 1'b0; ir_load = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // 1: reset, push, load and decode
    step(0, 0, 16'h0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    step(1, 1, 16'h3501, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    chk("t1_ir", 32'(ir), 32'h3501);
    chk("t1_opcode", 32'(opcode), 32'h3);
    chk("t1_mode", 32'(mode), 0);
    chk("t1_rd", 32'(rd), 32'h5);
    chk("t1_rs1", 32'(rs1), 0);
    chk("t1_imm", 32'(imm), 1);
    chk("t1_imm_ext", 32'(imm_ext), 32'h0001);
    chk("t1_valid", 32'(ir_valid), 1);

    // 2: sign extension, push order
    step(1, 1, 16'h6146, 0, 0);
    step(1, 1, 16'h601F, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    chk("t2_ext_pos", 32'(imm_ext), 32'h0006);
    step(1, 0, 16'h0, 1, 0);
    chk("t2_ext_neg", 32'(imm_ext), 32'hFFFF);
    chk("t2_ir", 32'(ir), 32'h601F);

    // 3: fill, refused push while full, pointer wrap
    for (int i = 0; i < 4; i++) step(1, 1, 16'(16'hA000 + i), 0, 0);
    chk("t3_full_count", 32'(count), 4);
    chk("t3_full_ready", 32'(in_ready), 0);
    step(1, 1, 16'hDEAD, 1, 0);
    chk("t3_after_count", 32'(count), 3);
    chk("t3_after_ir", 32'(ir), 32'hA000);
    for (int i = 0; i < 6; i++) step(1, 1, 16'(16'hB000 + i), 1, 0);
    chk("t3_wrap_ir", 32'(ir), 32'hB002);
    chk("t3_wrap_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 1, 0);
    chk("t3_drain_ir", 32'(ir), 32'hB005);
    chk("t3_drain_count", 32'(count), 0);

    // 4: push + load on empty gives a bubble, word still queued
    step(1, 1, 16'h1234, 1, 0);
    chk("t4_bubble", 32'(ir_valid), 0);
    chk("t4_count", 32'(count), 1);
    step(1, 0, 16'h0, 1, 0);
    chk("t4_ir", 32'(ir), 32'h1234);
    chk("t4_valid", 32'(ir_valid), 1);

    // 5: flush beats push and load
    for (int i = 0; i < 3; i++) step(1, 1, 16'(16'hC000 + i), 0, 0);
    step(1, 1, 16'hBEEF, 1, 1);
    chk("t5_count", 32'(count), 0);
    chk("t5_valid", 32'(ir_valid), 0);
    chk("t5_ir_hold", 32'(ir), 32'h1234);
    step(1, 1, 16'h4321, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    chk("t5_new_ir", 32'(ir), 32'h4321);
    chk("t5_new_count", 32'(count), 0);

    // 6: reset mid-stream overrides push and load
    step(1, 1, 16'h7777, 0, 0);
    step(1, 1, 16'h8888, 0, 0);
    chk("t6_pre_count", 32'(count), 2);
    step(0, 1, 16'h5555, 1, 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_ir", 32'(ir), 0);
    chk("t6_valid", 32'(ir_valid), 0);
    chk("t6_ready", 32'(in_ready), 1);
    chk("t6_fields", 32'({opcode, mode, rd, rs1, imm}), 0);
    chk("t6_imm_ext", 32'(imm_ext), 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
